lsb_watermark_embed: RTL and testbench
======================================

# lsb_watermark_embed

Streaming LSB watermark embedder for the pixel datapath. It holds a serially loaded watermark pattern in a shift register and replaces the least-significant bit of every pixel of a frame with the next pattern bit. It sits directly downstream of the pixel source/register stage and upstream of the frame output stage, using valid/ready handshakes on both sides with one output register stage.

## Interface
- PIX_W, 8: pixel width in bits (≥2)
- IMG_W, 64: pixels per row
- IMG_H, 64: rows per frame
- WM_LEN, 64: watermark pattern length in bits (2..256)
- LFSR_SEED, 16'hACE1: scrambler seed, nonzero; used only with WM_SCRAMBLE_EN
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wm_load  in  1  pattern load strobe; one bit is shifted in per cycle while high
- wm_bit_in  in  1  serial pattern bit
- wm_ready  out  1  a full pattern is loaded
- s_valid / s_ready  in / out  1 / 1  input pixel handshake
- s_data  in  PIX_W  input pixel
- s_sof  in  1  first pixel of frame, qualified by s_valid
- m_valid / m_ready  out / in  1 / 1  output pixel handshake
- m_data  out  PIX_W  watermarked pixel
- m_sof, m_eof  out  1  frame start / last pixel markers, aligned with m_data
- sof_err  out  1  sticky; pixel dropped outside a frame, or s_sof mid-frame

## Operation
- Reset values: state EMPTY; wm_ready, s_ready, m_valid, m_sof, m_eof and sof_err are 0; m_data is 0; pattern and counters are 0.
- FSM states:
  - EMPTY: s_ready=0. Each cycle with wm_load=1 shifts wm_bit_in into pattern[0] (pattern << 1) and increments load_cnt. When load_cnt reaches WM_LEN, go to READY with wm_ready=1.
  - READY: s_ready follows the output rule.
    - An accepted pixel with s_sof=1 is embedded as pixel 0, m_sof=1, and the FSM goes to FRAME.
    - An accepted pixel without s_sof is discarded and sets sof_err.
    - wm_load=1 clears wm_ready and load_cnt and goes to EMPTY; the bit presented that cycle is the first new bit.
  - FRAME: each accepted pixel is embedded and col/row advance. col wraps at IMG_W-1 and increments row.
    - On the pixel with col=IMG_W-1 and row=IMG_H-1, m_eof=1 and the FSM returns to READY.
    - s_sof mid-frame: the pixel is treated as pixel 0 of a new frame (counters and index reset, m_sof=1) and sof_err is set.
    - wm_load is ignored in FRAME.
- Embedding:
  - m_data = {s_data[PIX_W-1:1], b}, with b = pattern[WM_LEN-1-idx].
  - idx starts at 0 on each sof and wraps from WM_LEN-1 to 0, so the pattern tiles across the frame.
  - The first loaded bit is used for pixel 0.
- The output register holds m_data/m_sof/m_eof stable while m_valid=1 and m_ready=0.
- sof_err clears only on reset.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N appears with m_valid=1 after edge N.
- s_ready = (state≠EMPTY) && (!m_valid || m_ready). This is combinational from m_ready and gives full throughput of 1 pixel/cycle.
- Pattern load takes exactly WM_LEN cycles with wm_load held high. Gaps (wm_load low) pause the load without losing bits.
- Reset asserted mid-frame: outputs go to their reset values immediately, and the pattern must be reloaded.
- Simultaneous m_ready=1 and a new accept: the output register is replaced in the same edge, with no bubble.

## Configuration
- WM_SCRAMBLE_EN defined: b is XORed with lfsr[0].
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Loaded with LFSR_SEED on every sof pixel.
  - Advances once per accepted in-frame pixel, after use.
- Undefined: no LFSR logic; b is the raw pattern bit.

## Structure
- Shared package wm_pkg holds:
  - FSM state encoding (ST_EMPTY, ST_READY, ST_FRAME)
  - LFSR tap constant
  - default LFSR_SEED
- One sub-module, wm_lfsr (ports: clk, rst_n, load, en, q[15:0]). It is instantiated only under WM_SCRAMBLE_EN.

## Test plan
- Reset → all outputs 0 and s_ready=0. Then load 64 bits of 0xF0F0_F0F0_F0F0_F0F0 MSB-first → wm_ready=1 after exactly 64 wm_load cycles.
- Full frame of pixels 0xAA with m_ready=1 (scramble off) → output pixels 0 to 3 are 0xAB, pixels 4 to 7 are 0xAA, repeating. m_sof only on pixel 0, m_eof only on pixel 4095. Latency is 1 cycle and there are no bubbles.
- Random m_ready backpressure at 50% → m_data is held stable while stalled, no pixel is lost or duplicated, and the output sequence equals the model.
- Pixel without s_sof in READY → it is dropped, no m_valid, sof_err=1. A following sof frame embeds normally.
- s_sof at pixel 100 of a frame → that pixel uses pattern bit 0 with m_sof=1, sof_err=1, and m_eof follows 4095 pixels later.
- WM_SCRAMBLE_EN defined, pattern all zeros, pixels 0x00 → the output LSB sequence equals the LFSR bit sequence from seed 0xACE1, restarting on each frame.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared definitions for the LSB watermark embedder: FSM encoding, LFSR taps
// and the default scrambler seed, plus the one-step LFSR helper.
package wm_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_FRAME = 2'd2
    } wm_state_e;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // One shift of the scrambler: feedback enters at bit 15, output is bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/wm_lfsr.sv
// 16-bit Fibonacci scrambler LFSR. A load strobe restarts the sequence from
// SEED and steps it once in the same edge, because the seed bit itself is
// consumed by the pixel that triggers the load.
module wm_lfsr
    import wm_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // LFSR state: restart on load, step once per enabled pixel, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= lfsr_step(SEED);
        end else if (en) begin
            r_q <= lfsr_step(r_q);
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/lsb_watermark_embed.sv
// Streaming LSB watermark embedder. A serially loaded pattern replaces the
// LSB of each pixel of a frame, tiling from the first loaded bit at every
// start of frame. One output register stage with valid/ready on both sides.
// Optional build macro: WM_SCRAMBLE_EN (XOR each pattern bit with an LFSR
// sequence that restarts at every start of frame).
module lsb_watermark_embed
    import wm_pkg::*;
#(
    parameter int          PIX_W     = 8,
    parameter int          IMG_W     = 64,
    parameter int          IMG_H     = 64,
    parameter int          WM_LEN    = 64,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wm_load,
    input  logic             wm_bit_in,
    output logic             wm_ready,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eof,
    output logic             sof_err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IW = $clog2(WM_LEN);
    localparam int LW = $clog2(WM_LEN + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WM_LEN - 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(WM_LEN - 1);

    wm_state_e          r_state, w_state_nxt;
    logic [WM_LEN-1:0]  r_pattern, w_pattern_nxt;
    logic [LW-1:0]      r_load_cnt, w_load_cnt_nxt;
    logic               r_wm_ready, w_wm_ready_nxt;
    logic [CW-1:0]      r_col, w_col_nxt;
    logic [RW-1:0]      r_row, w_row_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic               r_sof_err, w_sof_err_nxt;
    logic               r_m_valid, w_m_valid_nxt;
    logic [PIX_W-1:0]   r_m_data, w_m_data_nxt;
    logic               r_m_sof, w_m_sof_nxt;
    logic               r_m_eof, w_m_eof_nxt;

    logic               w_s_ready;
    logic               w_accept;
    logic               w_embed;
    logic [CW-1:0]      w_pix_col;
    logic [RW-1:0]      w_pix_row;
    logic [IW-1:0]      w_pix_idx;
    logic               w_pix_eof;
    logic               w_wm_bit;
    logic               w_scr_bit;

    // Input side may take a pixel whenever a pattern is present and the
    // output register is empty or draining this cycle.
    assign w_s_ready = (r_state != ST_EMPTY) && (!r_m_valid || m_ready);
    assign w_accept  = s_valid && w_s_ready;

    // A start-of-frame pixel is always position 0, whatever the counters say.
    assign w_pix_col = s_sof ? {CW{1'b0}} : r_col;
    assign w_pix_row = s_sof ? {RW{1'b0}} : r_row;
    assign w_pix_idx = s_sof ? {IW{1'b0}} : r_idx;
    assign w_pix_eof = (w_pix_col == COL_LAST) && (w_pix_row == ROW_LAST);
    // The first loaded bit sits at the MSB of the pattern shift register.
    assign w_wm_bit  = r_pattern[IDX_LAST - w_pix_idx];

`ifdef WM_SCRAMBLE_EN
    logic [15:0] w_lfsr_q;
    logic        w_lfsr_load;
    logic        w_lfsr_en;

    assign w_lfsr_load = w_embed && s_sof;
    assign w_lfsr_en   = w_embed && !s_sof;
    // The sof pixel consumes the seed bit directly; the LFSR reloads behind it.
    assign w_scr_bit   = s_sof ? LFSR_SEED[0] : w_lfsr_q[0];

    wm_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_lfsr_load),
        .en    (w_lfsr_en),
        .q     (w_lfsr_q)
    );
`else
    assign w_scr_bit = 1'b0;
`endif

    // FSM next state: pattern loading, frame admission and sof error tracking.
    // A pixel accepted in the same READY cycle as wm_load is discarded, since
    // the pattern it would use is being replaced.
    always_comb begin
        w_state_nxt    = r_state;
        w_pattern_nxt  = r_pattern;
        w_load_cnt_nxt = r_load_cnt;
        w_wm_ready_nxt = r_wm_ready;
        w_sof_err_nxt  = r_sof_err;
        w_embed        = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (wm_load) begin
                    w_pattern_nxt  = {r_pattern[WM_LEN-2:0], wm_bit_in};
                    w_load_cnt_nxt = r_load_cnt + LW'(1);
                    if (r_load_cnt == LOAD_LAST) begin
                        w_state_nxt    = ST_READY;
                        w_wm_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_EMPTY;
                    end
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_READY: begin
                if (wm_load) begin
                    w_state_nxt    = ST_EMPTY;
                    w_wm_ready_nxt = 1'b0;
                    w_pattern_nxt  = {r_pattern[WM_LEN-2:0], wm_bit_in};
                    w_load_cnt_nxt = LW'(1);
                end else if (w_accept) begin
                    if (s_sof) begin
                        w_embed       = 1'b1;
                    end else begin
                        w_sof_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_FRAME: begin
                if (w_accept) begin
                    w_embed = 1'b1;
                    if (s_sof) begin
                        w_sof_err_nxt = 1'b1;
                    end else begin
                        w_sof_err_nxt = r_sof_err;
                    end
                end else begin
                    w_state_nxt = ST_FRAME;
                end
            end
            default: begin
                w_state_nxt    = ST_EMPTY;
                w_wm_ready_nxt = 1'b0;
                w_load_cnt_nxt = {LW{1'b0}};
            end
        endcase
        if (w_embed) begin
            w_state_nxt = w_pix_eof ? ST_READY : ST_FRAME;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Frame position and pattern index advance for every embedded pixel.
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        w_idx_nxt = r_idx;
        if (w_embed) begin
            if (w_pix_col == COL_LAST) begin
                w_col_nxt = {CW{1'b0}};
                w_row_nxt = (w_pix_row == ROW_LAST) ? {RW{1'b0}} : w_pix_row + RW'(1);
            end else begin
                w_col_nxt = w_pix_col + CW'(1);
                w_row_nxt = w_pix_row;
            end
            w_idx_nxt = (w_pix_idx == IDX_LAST) ? {IW{1'b0}} : w_pix_idx + IW'(1);
        end else begin
            w_idx_nxt = r_idx;
        end
    end

    // Output register: load on embed, empty on drain, otherwise hold steady.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;
        w_m_sof_nxt   = r_m_sof;
        w_m_eof_nxt   = r_m_eof;
        if (w_embed) begin
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = {s_data[PIX_W-1:1], w_wm_bit ^ w_scr_bit};
            w_m_sof_nxt   = s_sof;
            w_m_eof_nxt   = w_pix_eof;
        end else if (m_ready) begin
            w_m_valid_nxt = 1'b0;
        end else begin
            w_m_valid_nxt = r_m_valid;
        end
    end

    // State registers; reset empties the pattern so it must be reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_pattern  <= {WM_LEN{1'b0}};
            r_load_cnt <= {LW{1'b0}};
            r_wm_ready <= 1'b0;
            r_col      <= {CW{1'b0}};
            r_row      <= {RW{1'b0}};
            r_idx      <= {IW{1'b0}};
            r_sof_err  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= {PIX_W{1'b0}};
            r_m_sof    <= 1'b0;
            r_m_eof    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pattern  <= w_pattern_nxt;
            r_load_cnt <= w_load_cnt_nxt;
            r_wm_ready <= w_wm_ready_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_idx      <= w_idx_nxt;
            r_sof_err  <= w_sof_err_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_m_data   <= w_m_data_nxt;
            r_m_sof    <= w_m_sof_nxt;
            r_m_eof    <= w_m_eof_nxt;
        end
    end

    assign wm_ready = r_wm_ready;
    assign s_ready  = w_s_ready;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_sof    = r_m_sof;
    assign m_eof    = r_m_eof;
    assign sof_err  = r_sof_err;

endmodule

// File: tb/tb_lsb_watermark_embed.sv
// Self-checking bench for lsb_watermark_embed. A frame-position model
// (pixel number within frame, pattern bit = pattern[pos mod WM_LEN]) predicts
// every output pixel; a queue of expected pixels checks latency, ordering,
// loss and duplication, and stalled outputs are checked for stability.
module tb_lsb_watermark_embed;

    localparam int PIX_W     = 8;
    localparam int IMG_W     = 64;
    localparam int IMG_H     = 64;
    localparam int WM_LEN    = 64;
    localparam int FRAME_PIX = IMG_W * IMG_H;

    typedef struct packed {
        logic [PIX_W-1:0] d;
        logic             sof;
        logic             eof;
    } pix_t;

    logic             clk;
    logic             rst_n;
    logic             wm_load;
    logic             wm_bit_in;
    logic             wm_ready;
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             s_sof;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_sof;
    logic             m_eof;
    logic             sof_err;

    int   checks;
    int   failures;

    // Reference model state
    bit   wm_pat [WM_LEN];
    bit   lfsr_bits [FRAME_PIX];
    bit   mdl_wm_ready;
    bit   mdl_in_frame;
    int   mdl_pos;
    bit   mdl_err;
    pix_t exp_q [$];
    pix_t out_log [$];
    bit   hold_pend;
    pix_t hold_val;

    lsb_watermark_embed #(
        .PIX_W     (PIX_W),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .WM_LEN    (WM_LEN),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wm_load   (wm_load),
        .wm_bit_in (wm_bit_in),
        .wm_ready  (wm_ready),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .sof_err   (sof_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        exp_q.delete();
        mdl_wm_ready = 1'b0;
        mdl_in_frame = 1'b0;
        mdl_pos      = 0;
        mdl_err      = 1'b0;
        hold_pend    = 1'b0;
    endtask

    // Expected result of one accepted input pixel, from frame position alone.
    task automatic model_accept(input logic [PIX_W-1:0] sd, input logic ssof);
        pix_t e;
        bit   b;
        if (ssof) begin
            if (mdl_in_frame) mdl_err = 1'b1;
            mdl_pos      = 0;
            mdl_in_frame = 1'b1;
        end else if (!mdl_in_frame) begin
            mdl_err = 1'b1;
            return;
        end
        b = wm_pat[mdl_pos % WM_LEN];
`ifdef WM_SCRAMBLE_EN
        b = b ^ lfsr_bits[mdl_pos];
`endif
        e.d   = {sd[PIX_W-1:1], b};
        e.sof = ssof;
        e.eof = (mdl_pos == FRAME_PIX - 1);
        exp_q.push_back(e);
        if (e.eof) mdl_in_frame = 1'b0;
        mdl_pos++;
    endtask

    // One clock of streaming: check state left by the last edge, drive new
    // inputs, score any output transfer and feed any input accept to the model.
    task automatic run_cycle(input logic sv, input logic [PIX_W-1:0] sd,
                             input logic ssof, input logic mr, output bit accepted);
        pix_t e;
        bit   exp_sready;
        @(negedge clk);
        if (hold_pend) begin
            checks++;
            if (m_valid !== 1'b1 || {m_data, m_sof, m_eof} !== hold_val) begin
                failures++;
                $display("FAIL stall_hold: got v=%b %h/%b/%b want v=1 %h/%b/%b",
                         m_valid, m_data, m_sof, m_eof, hold_val.d, hold_val.sof, hold_val.eof);
            end
        end
        checks++;
        if (m_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL m_valid: got %b want %b", m_valid, exp_q.size() != 0);
        end
        checks++;
        if (sof_err !== mdl_err || wm_ready !== mdl_wm_ready) begin
            failures++;
            $display("FAIL flags: got sof_err=%b wm_ready=%b want %b %b",
                     sof_err, wm_ready, mdl_err, mdl_wm_ready);
        end
        s_valid = sv; s_data = sd; s_sof = ssof; m_ready = mr; wm_load = 1'b0;
        #1;
        exp_sready = mdl_wm_ready && ((exp_q.size() == 0) || mr);
        checks++;
        if (s_ready !== exp_sready) begin
            failures++;
            $display("FAIL s_ready: got %b want %b", s_ready, exp_sready);
        end
        if (m_valid === 1'b1 && mr && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            out_log.push_back({m_data, m_sof, m_eof});
            checks++;
            if ({m_data, m_sof, m_eof} !== e) begin
                failures++;
                $display("FAIL pixel: got %h sof=%b eof=%b want %h sof=%b eof=%b",
                         m_data, m_sof, m_eof, e.d, e.sof, e.eof);
            end
        end
        hold_pend = (m_valid === 1'b1) && !mr;
        hold_val  = {m_data, m_sof, m_eof};
        accepted  = sv && (s_ready === 1'b1);
        if (accepted) model_accept(sd, ssof);
    endtask

    // Serial pattern load, MSB first, optionally pausing before bit gap_at.
    task automatic load_pattern(input logic [WM_LEN-1:0] pat, input int gap_at);
        mdl_wm_ready = 1'b0;
        s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < WM_LEN; k++) begin
            if (k == gap_at) begin
                @(negedge clk);
                wm_load = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    checks++;
                    if (wm_ready !== 1'b0 || s_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL load_gap: got wm_ready=%b s_ready=%b want 0 0",
                                 wm_ready, s_ready);
                    end
                end
            end
            @(negedge clk);
            if (k == 1 || k == WM_LEN - 1) begin
                checks++;
                if (wm_ready !== 1'b0 || s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL load_early: bit %0d got wm_ready=%b s_ready=%b want 0 0",
                             k, wm_ready, s_ready);
                end
            end
            wm_load   = 1'b1;
            wm_bit_in = pat[WM_LEN-1-k];
            wm_pat[k] = pat[WM_LEN-1-k];
        end
        @(negedge clk);
        wm_load = 1'b0;
        checks++;
        if (wm_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_done: got wm_ready=%b want 1", wm_ready);
        end
        mdl_wm_ready = 1'b1;
    endtask

    // Push n accepted pixels with random valid/ready duty, then drain.
    task automatic stream_frame(input int n_pix, input int sof_at2, input int ready_pct,
                                input int valid_pct, input bit rand_data,
                                input logic [PIX_W-1:0] fix_data, output int cyc);
        int               acc;
        bit               a;
        logic             sv, mr;
        logic [PIX_W-1:0] sd;
        acc = 0;
        cyc = 0;
        while (acc < n_pix && cyc < 4 * n_pix + 100) begin
            sv = ($urandom_range(99) < valid_pct);
            mr = ($urandom_range(99) < ready_pct);
            sd = rand_data ? PIX_W'($urandom) : fix_data;
            run_cycle(sv, sd, (acc == 0) || (acc == sof_at2), mr, a);
            if (a) acc++;
            cyc++;
        end
        checks++;
        if (acc != n_pix) begin
            failures++;
            $display("FAIL stream_budget: accepted %0d want %0d", acc, n_pix);
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b0, 1'b1, a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wm_load = 1'b0; wm_bit_in = 1'b0; s_valid = 1'b0; s_data = '0;
        s_sof = 1'b0; m_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({wm_ready, s_ready, m_valid, m_sof, m_eof, sof_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000",
                     {wm_ready, s_ready, m_valid, m_sof, m_eof, sof_err});
        end
        checks++;
        if (m_data !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h want 00", m_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        load_pattern(64'hF0F0_F0F0_F0F0_F0F0, 32);
    endtask

    task automatic test_full_frame();
        int         cyc;
        logic [7:0] want [8];
        want = '{8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        out_log.delete();
        stream_frame(FRAME_PIX, -1, 100, 100, 1'b0, 8'hAA, cyc);
        checks++;
        if (cyc != FRAME_PIX || out_log.size() != FRAME_PIX) begin
            failures++;
            $display("FAIL full_throughput: cycles=%0d outputs=%0d want %0d",
                     cyc, out_log.size(), FRAME_PIX);
        end
`ifndef WM_SCRAMBLE_EN
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_log.size() > i && out_log[i].d !== want[i]) begin
                failures++;
                $display("FAIL full_pix%0d: got %h want %h", i, out_log[i].d, want[i]);
            end
        end
`endif
        checks++;
        if (out_log.size() == FRAME_PIX &&
            (out_log[0].sof !== 1'b1 || out_log[FRAME_PIX-1].eof !== 1'b1)) begin
            failures++;
            $display("FAIL full_markers: got sof0=%b eof_last=%b want 1 1",
                     out_log[0].sof, out_log[FRAME_PIX-1].eof);
        end
    endtask

    task automatic test_no_sof();
        bit a;
        int cyc;
        run_cycle(1'b1, 8'h55, 1'b0, 1'b1, a);
        run_cycle(1'b0, '0, 1'b0, 1'b1, a);
        checks++;
        if (m_valid !== 1'b0 || sof_err !== 1'b1) begin
            failures++;
            $display("FAIL no_sof_drop: got m_valid=%b sof_err=%b want 0 1", m_valid, sof_err);
        end
        stream_frame(FRAME_PIX, -1, 100, 90, 1'b1, '0, cyc);
    endtask

    task automatic test_async_reset();
        bit a;
        for (int i = 0; i < 20; i++) run_cycle(1'b1, PIX_W'($urandom), i == 0, 1'b1, a);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wm_ready, s_ready, m_valid, m_sof, m_eof, sof_err} !== 6'b0 || m_data !== '0) begin
            failures++;
            $display("FAIL async_reset: got flags=%b data=%h want 000000 00",
                     {wm_ready, s_ready, m_valid, m_sof, m_eof, sof_err}, m_data);
        end
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_mid_sof();
        int cyc;
        out_log.delete();
        load_pattern({$urandom, $urandom}, 7);
        stream_frame(FRAME_PIX + 100, 100, 100, 100, 1'b1, '0, cyc);
        checks++;
        if (out_log.size() != FRAME_PIX + 100 || out_log[100].sof !== 1'b1 ||
            out_log[99].eof !== 1'b0 || out_log[FRAME_PIX+99].eof !== 1'b1 ||
            out_log[100].d[0] !== wm_pat[0]) begin
            failures++;
            $display("FAIL mid_sof: outputs=%0d sof100=%b eof_end=%b lsb100=%b want %0d 1 1 %b",
                     out_log.size(), out_log[100].sof, out_log[FRAME_PIX+99].eof,
                     out_log[100].d[0], FRAME_PIX + 100, wm_pat[0]);
        end
        checks++;
        if (sof_err !== 1'b1) begin
            failures++;
            $display("FAIL mid_sof_err: got %b want 1", sof_err);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        load_pattern({$urandom, $urandom}, -1);
        stream_frame(FRAME_PIX, -1, 50, 80, 1'b1, '0, cyc);
    endtask

`ifdef WM_SCRAMBLE_EN
    task automatic test_scramble();
        int cyc;
        test_async_reset();
        out_log.delete();
        load_pattern({WM_LEN{1'b0}}, -1);
        stream_frame(FRAME_PIX + 50, 50, 100, 100, 1'b0, 8'h00, cyc);
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (out_log.size() > i &&
                out_log[i].d[0] !== lfsr_bits[(i < 50) ? i : i - 50]) begin
                failures++;
                $display("FAIL scramble_bit%0d: got %b want %b", i, out_log[i].d[0],
                         lfsr_bits[(i < 50) ? i : i - 50]);
            end
        end
    endtask
`endif

    initial begin
        logic [15:0] l;
        bit          fb;
        checks   = 0;
        failures = 0;
        l = 16'hACE1;
        for (int k = 0; k < FRAME_PIX; k++) begin
            lfsr_bits[k] = l[0];
            fb = l[0] ^ l[2] ^ l[3] ^ l[5];
            l  = {fb, l[15:1]};
        end
        test_reset();
        test_load();
        test_full_frame();
        test_no_sof();
        test_async_reset();
        test_mid_sof();
        test_back_to_back();
`ifdef WM_SCRAMBLE_EN
        test_scramble();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
